can_cpu_arb: RTL and testbench
==============================

CAN_CPU_ARB -- requirements
Module: can_cpu_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles to wait for cpu_ack/cpu_err before aborting; legal range 1..255.
REQ-002 sysclk  in  1  single clock; all state updates on rising edge.
REQ-003 ponrst  in  1  reset, synchronous, active-high.
REQ-004 req  in  2  per-requester access request; bit0 = config sequencer, bit1 = message engine.
REQ-005 write  in  2  per-requester direction, 1 = write, 0 = read.
REQ-006 addr  in  64  per-requester address, requester i on addr[32i+31:32i].
REQ-007 wdat  in  64  per-requester write data, same packing as addr.
REQ-008 gnt  out  2  one-hot; high while that requester owns the bus.
REQ-009 done  out  2  one-cycle completion pulse to the owning requester.
REQ-010 err  out  2  one-cycle error pulse, coincident with done.
REQ-011 rdat  out  32  read data of the last completed access, shared by both requesters.
REQ-012 cpu_cs, cpu_write, cpu_read  out  1 each  CAN register bus strobes.
REQ-013 cpu_addr, cpu_wdat  out  32 each  CAN register bus address and write data.
REQ-014 cpu_rdat  in  32; cpu_ack  in  1; cpu_err  in  1  CAN register bus response.

Function
REQ-015 FSM SHALL have states IDLE, ACCESS and RESP, all registered.
REQ-016 IDLE with any req bit high: SHALL select a winner, latch its write/addr/wdat, set gnt, and enter ACCESS on the next edge.
REQ-017 Arbitration SHALL be round-robin: when both request, the requester not granted last wins; after reset requester 0 has priority.
REQ-018 In ACCESS, cpu_cs SHALL be 1; cpu_write SHALL equal the latched write bit and cpu_read its inverse.
REQ-019 In ACCESS, cpu_addr/cpu_wdat SHALL hold the latched values; in every other state all cpu_* outputs SHALL be 0.
REQ-020 ACCESS with cpu_ack=1 or cpu_err=1: SHALL enter RESP; cpu_cs SHALL drop on that edge.
REQ-021 ACCESS with cpu_ack=1 and latched write=0: SHALL capture cpu_rdat into rdat.
REQ-022 RESP SHALL last exactly one cycle and pulse done[owner], then go to IDLE and clear gnt.
REQ-023 err[owner] SHALL pulse in RESP if cpu_err was seen; simultaneous ack and err counts as error, and rdat SHALL be left unchanged.
REQ-024 Latency: req sampled in IDLE at cycle N gives cpu_cs at N+1; ack at cycle M gives done at M+1.
REQ-025 Back-to-back accesses SHALL have at least one IDLE cycle between them.
REQ-026 Deasserting req during ACCESS SHALL NOT abort the access; it completes normally.
REQ-027 A requester SHALL hold req until it sees done; requests arriving in ACCESS or RESP wait for IDLE.

Reset
REQ-028 ponrst=1 at an edge SHALL force IDLE and clear gnt, done, err, rdat, all cpu_* outputs, the timeout counter and the round-robin pointer (pointer = requester 0).
REQ-029 Reset asserted mid-ACCESS SHALL abort without any done or err pulse.

Configuration
REQ-030 With CAN_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL run in ACCESS; reaching TIMEOUT_CYC with no ack/err SHALL enter RESP with err and done pulsed.
REQ-031 Without CAN_ARB_TIMEOUT_EN: there SHALL be no counter, and ACCESS waits indefinitely for ack/err.

Structure
REQ-032 Shared package can_arb_pkg SHALL hold the FSM state enum, the requester index constants and the TIMEOUT_CYC default.
REQ-033 Sub-module can_rr_pick SHALL implement the two-input round-robin selection (combinational, with the pointer kept in the parent).

Verification
REQ-034 Single write: req=01, addr0=0x0008, wdat0=0x000A, ack 3 cycles after cs -> cpu_cs 4 cycles, cpu_write=1, done[0] one cycle after ack, err=00.
REQ-035 Read: req=10, write=0, addr1=0x0200, ack with cpu_rdat=0x7C01A579 -> rdat=0x7C01A579, done[1] pulse, cpu_read=1 during cs.
REQ-036 Contention: req=11 held for 4 accesses, ack in 1 cycle each -> grant order 0,1,0,1, with one IDLE cycle between accesses.
REQ-037 Error: cpu_ack and cpu_err high together -> done and err pulse together, rdat unchanged.
REQ-038 Timeout (macro on, TIMEOUT_CYC=16), no ack -> err pulse after 16 ACCESS cycles; macro off -> cpu_cs stays high for 1000 cycles.
REQ-039 Reset pulse mid-ACCESS -> next cycle all outputs 0, no done; after reset, req=11 grants requester 0.

Source files
------------

// File: rtl/can_arb_pkg.sv
// can_arb_pkg -- shared definitions for the CAN register-bus arbiter.
//   state_t / ST_*    : arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   REQ_CFG, REQ_MSG  : requester indices (config sequencer, message engine)
//   NUM_REQ           : number of requesters
//   TIMEOUT_CYC_DEF   : default access timeout in cycles (1..255)
package can_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned REQ_CFG         = 0;
  localparam int unsigned REQ_MSG         = 1;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/can_cpu_arb_if.sv
// can_cpu_arb_if -- requester side and CAN register bus side of the arbiter.
//   Requester side : req, write, addr, wdat (in)  ; gnt, done, err, rdat (out)
//                    requester i uses bits [i] and word [32i+31:32i]
//   CAN bus side   : cpu_cs, cpu_write, cpu_read, cpu_addr, cpu_wdat (out)
//                    cpu_rdat, cpu_ack, cpu_err (in)
//   Modports: slave = arbiter, master = everything around it.
interface can_cpu_arb_if;
  logic [1:0]  req;
  logic [1:0]  write;
  logic [63:0] addr;
  logic [63:0] wdat;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [31:0] rdat;
  logic        cpu_cs;
  logic        cpu_write;
  logic        cpu_read;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdat;
  logic [31:0] cpu_rdat;
  logic        cpu_ack;
  logic        cpu_err;

  modport slave (
    input  req, write, addr, wdat, cpu_rdat, cpu_ack, cpu_err,
    output gnt, done, err, rdat, cpu_cs, cpu_write, cpu_read, cpu_addr, cpu_wdat
  );

  modport master (
    output req, write, addr, wdat, cpu_rdat, cpu_ack, cpu_err,
    input  gnt, done, err, rdat, cpu_cs, cpu_write, cpu_read, cpu_addr, cpu_wdat
  );
endinterface

// File: rtl/can_rr_pick.sv
// can_rr_pick -- combinational two-input round-robin pick.
//   req_i  : request bits
//   prio_i : index of the requester that wins a tie
//   pick_o : one-hot winner (0 when nothing requests)
//   idx_o  : winner index (only meaningful when |req_i)
module can_rr_pick (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] pick_o,
  output logic       idx_o
);
  // The priority holder wins whenever it asks; otherwise the other one gets it.
  assign idx_o  = req_i[prio_i] ? prio_i : ~prio_i;
  assign pick_o = (req_i == 2'b00) ? 2'b00 : (idx_o ? 2'b10 : 2'b01);
endmodule

// File: rtl/can_cpu_arb.sv
// can_cpu_arb -- two-requester arbiter onto the CAN controller register bus.
//   sysclk : clock, all state on the rising edge
//   ponrst : synchronous active-high reset
//   bus    : can_cpu_arb_if.slave (requester handshake + CAN register bus)
//   TIMEOUT_CYC : access abort limit in cycles (1..255), only with the
//                 CAN_ARB_TIMEOUT_EN macro defined; otherwise ACCESS waits
//                 indefinitely for cpu_ack/cpu_err.
// Flow: IDLE picks a winner and latches its request, ACCESS drives the
// register bus until ack/err (or timeout), RESP pulses done/err for one cycle.
module can_cpu_arb
  import can_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          sysclk,
  input  logic          ponrst,
  can_cpu_arb_if.slave  bus
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
    $error("can_cpu_arb: TIMEOUT_CYC must be within 1..255");
  end

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;
  logic        prio_q, prio_d;   // requester that wins the next tie
  logic [1:0]  pick;
  logic        pick_idx;
  logic        acc;
  logic        tmo;

  can_rr_pick u_pick (
    .req_i  (bus.req),
    .prio_i (prio_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  assign acc = (state_q == ST_ACCESS);

`ifdef CAN_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  // Counter is zero on ACCESS entry, so the limit hits on the
  // TIMEOUT_CYC-th ACCESS cycle.
  assign tmo   = acc && (cnt_q == 8'(TIMEOUT_CYC - 1));
  assign cnt_d = acc ? (cnt_q + 8'd1) : 8'd0;

  always_ff @(posedge sysclk) begin
    if (ponrst) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d   = pick;
          wr_d    = bus.write[pick_idx];
          addr_d  = pick_idx ? bus.addr[63:32] : bus.addr[31:0];
          wdat_d  = pick_idx ? bus.wdat[63:32] : bus.wdat[31:0];
          prio_d  = ~pick_idx;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // ack in the timeout cycle still completes cleanly
        if (bus.cpu_ack || bus.cpu_err || tmo) begin
          done_d  = 1'b1;
          err_d   = bus.cpu_err || (tmo && !bus.cpu_ack);
          if (bus.cpu_ack && !bus.cpu_err && !wr_q) rdat_d = bus.cpu_rdat;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (ponrst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      prio_q  <= prio_d;
    end
  end

  // done/err are only set for the RESP cycle, where gnt still names the owner.
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q ? gnt_q : 2'b00;
  assign bus.err       = err_q  ? gnt_q : 2'b00;
  assign bus.rdat      = rdat_q;
  assign bus.cpu_cs    = acc;
  assign bus.cpu_write = acc & wr_q;
  assign bus.cpu_read  = acc & ~wr_q;
  assign bus.cpu_addr  = acc ? addr_q : 32'd0;
  assign bus.cpu_wdat  = acc ? wdat_q : 32'd0;

endmodule

// File: tb/tb_can_cpu_arb.sv
// tb_can_cpu_arb -- self-checking bench for can_cpu_arb: reset state, a table
// of single accesses, reset abort, contention, timeout / no-timeout, and a
// randomized run checked against a transaction-level model.
module tb_can_cpu_arb;

  logic sysclk = 1'b0;
  logic ponrst;
  always #5 sysclk = ~sysclk;

  can_cpu_arb_if bus();

  can_cpu_arb #(.TIMEOUT_CYC(16)) dut (
    .sysclk (sysclk),
    .ponrst (ponrst),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1;
    int          dly;
    logic        ack, er;
    logic [31:0] crd;
    logic [1:0]  egnt;
    int          ecs;
    logic        ewr;
    logic [31:0] eaddr, ewdat, erdat;
    logic        eerr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".gnt"},       32'(bus.gnt), 32'd0);
    chk({nm, ".done"},      32'(bus.done), 32'd0);
    chk({nm, ".err"},       32'(bus.err), 32'd0);
    chk({nm, ".cpu_cs"},    32'(bus.cpu_cs), 32'd0);
    chk({nm, ".cpu_write"}, 32'(bus.cpu_write), 32'd0);
    chk({nm, ".cpu_read"},  32'(bus.cpu_read), 32'd0);
    chk({nm, ".cpu_addr"},  bus.cpu_addr, 32'd0);
    chk({nm, ".cpu_wdat"},  bus.cpu_wdat, 32'd0);
  endtask

  // Waits up to lim cycles for cpu_cs; reports cycles waited.
  task automatic wait_cs(input int lim, output int waited);
    waited = 0;
    while (bus.cpu_cs !== 1'b1 && waited < lim) begin
      tick();
      waited++;
    end
    chk("cs_seen", 32'(bus.cpu_cs), 32'd1);
  endtask

  // Called in the first ACCESS cycle; applies the response in ACCESS cycle
  // 'dly' and returns how many cycles cpu_cs was high.
  task automatic respond(input int dly, input logic ack, input logic er,
                         input logic [31:0] crd, output int cs_cnt);
    cs_cnt = 0;
    while (bus.cpu_cs === 1'b1 && cs_cnt < 2000) begin
      if (cs_cnt == dly) begin
        bus.cpu_ack  = ack;
        bus.cpu_err  = er;
        bus.cpu_rdat = crd;
      end
      cs_cnt++;
      tick();
      bus.cpu_ack = 1'b0;
      bus.cpu_err = 1'b0;
    end
  endtask

  task automatic do_reset();
    ponrst = 1'b1;
    tick();
    tick();
    ponrst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    int          w, n, own;
    logic [1:0]  rq, wr, eg;
    logic [63:0] ra, rd;
    int          dly, rk;
    logic        ack, er, drop;
    logic [31:0] crd, m_rdat;
    int          m_prio;

    //          req    wr     a0         a1         d0         d1         dly ack er crd            egnt  ecs ewr eaddr      ewdat      erdat          eerr
    tbl[0] = '{2'b01, 2'b01, 32'h0008, 32'h0,    32'h000A,  32'h0,     3, 1'b1, 1'b0, 32'h0,        2'b01, 4, 1'b1, 32'h0008, 32'h000A, 32'h0,        1'b0};
    tbl[1] = '{2'b10, 2'b00, 32'h0,    32'h0200, 32'h0,     32'h0,     1, 1'b1, 1'b0, 32'h7C01A579, 2'b10, 2, 1'b0, 32'h0200, 32'h0,    32'h7C01A579, 1'b0};
    tbl[2] = '{2'b01, 2'b00, 32'h0010, 32'h0,    32'h0,     32'h0,     0, 1'b1, 1'b1, 32'hDEADBEEF, 2'b01, 1, 1'b0, 32'h0010, 32'h0,    32'h7C01A579, 1'b1};
    tbl[3] = '{2'b10, 2'b10, 32'h0,    32'h0044, 32'h0,     32'h0055,  2, 1'b0, 1'b1, 32'h0,        2'b10, 3, 1'b1, 32'h0044, 32'h0055, 32'h7C01A579, 1'b1};
    tbl[4] = '{2'b01, 2'b00, 32'h03FC, 32'h0,    32'h0,     32'h0,     0, 1'b1, 1'b0, 32'h12345678, 2'b01, 1, 1'b0, 32'h03FC, 32'h0,    32'h12345678, 1'b0};
    tbl[5] = '{2'b11, 2'b01, 32'h0100, 32'h0104, 32'h0011,  32'h0022,  1, 1'b1, 1'b0, 32'hCAFEF00D, 2'b10, 2, 1'b0, 32'h0104, 32'h0022, 32'hCAFEF00D, 1'b0};
    tbl[6] = '{2'b01, 2'b01, 32'h0020, 32'h0,    32'h0000ABCD, 32'h0,  0, 1'b1, 1'b0, 32'hFFFFFFFF, 2'b01, 1, 1'b1, 32'h0020, 32'hABCD,  32'hCAFEF00D, 1'b0};

    bus.req = '0; bus.write = '0; bus.addr = '0; bus.wdat = '0;
    bus.cpu_ack = 1'b0; bus.cpu_err = 1'b0; bus.cpu_rdat = '0;

    // Reset state
    do_reset();
    chk_quiet("reset");
    chk("reset.rdat", bus.rdat, 32'd0);

    // Table of single accesses
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      bus.req = v.req; bus.write = v.wr;
      bus.addr = {v.a1, v.a0}; bus.wdat = {v.d1, v.d0};
      wait_cs(8, w);
      chk($sformatf("t%0d.latency", i),   32'(w), 32'd1);
      chk($sformatf("t%0d.gnt", i),       32'(bus.gnt), 32'(v.egnt));
      chk($sformatf("t%0d.cpu_write", i), 32'(bus.cpu_write), 32'(v.ewr));
      chk($sformatf("t%0d.cpu_read", i),  32'(bus.cpu_read), 32'(!v.ewr));
      chk($sformatf("t%0d.cpu_addr", i),  bus.cpu_addr, v.eaddr);
      chk($sformatf("t%0d.cpu_wdat", i),  bus.cpu_wdat, v.ewdat);
      respond(v.dly, v.ack, v.er, v.crd, n);
      chk($sformatf("t%0d.cs_cycles", i), 32'(n), 32'(v.ecs));
      chk($sformatf("t%0d.done", i),      32'(bus.done), 32'(v.egnt));
      chk($sformatf("t%0d.err", i),       32'(bus.err), v.eerr ? 32'(v.egnt) : 32'd0);
      chk($sformatf("t%0d.rdat", i),      bus.rdat, v.erdat);
      bus.req = 2'b00;
      tick();
      chk($sformatf("t%0d.idle_gnt", i),  32'(bus.gnt), 32'd0);
      chk($sformatf("t%0d.idle_done", i), 32'(bus.done), 32'd0);
    end

    // Reset during ACCESS by requester 0 (its grant would hand priority to 1)
    bus.req = 2'b01; bus.write = 2'b01; bus.addr = 64'h55; bus.wdat = 64'h66;
    wait_cs(8, w);
    tick();
    chk("abort.still_cs", 32'(bus.cpu_cs), 32'd1);
    ponrst = 1'b1;
    tick();
    chk_quiet("abort");
    chk("abort.rdat", bus.rdat, 32'd0);
    ponrst = 1'b0;
    bus.req = 2'b11; bus.write = 2'b11;
    bus.addr = {32'h0B00, 32'h0A00}; bus.wdat = {32'h2, 32'h1};

    // Contention: requester 0 first after reset, then strict alternation
    for (int a = 0; a < 4; a++) begin
      eg = (a % 2 == 0) ? 2'b01 : 2'b10;
      wait_cs(8, w);
      chk($sformatf("rr%0d.wait", a), 32'(w), 32'd1);
      chk($sformatf("rr%0d.gnt", a),  32'(bus.gnt), 32'(eg));
      chk($sformatf("rr%0d.addr", a), bus.cpu_addr, (a % 2 == 0) ? 32'h0A00 : 32'h0B00);
      respond(0, 1'b1, 1'b0, 32'h0, n);
      chk($sformatf("rr%0d.done", a), 32'(bus.done), 32'(eg));
      tick();
      chk($sformatf("rr%0d.idle_cs", a),  32'(bus.cpu_cs), 32'd0);
      chk($sformatf("rr%0d.idle_gnt", a), 32'(bus.gnt), 32'd0);
    end
    bus.req = 2'b00;
    tick();

    // Stuck register bus
    bus.req = 2'b01; bus.write = 2'b00; bus.addr = 64'h300;
    wait_cs(8, w);
`ifdef CAN_ARB_TIMEOUT_EN
    respond(100000, 1'b0, 1'b0, 32'h0, n);
    chk("tmo.cs_cycles", 32'(n), 32'd16);
    chk("tmo.done", 32'(bus.done), 32'd1);
    chk("tmo.err",  32'(bus.err), 32'd1);
    chk("tmo.rdat", bus.rdat, 32'd0);
`else
    respond(1000, 1'b1, 1'b0, 32'h0BADF00D, n);
    chk("notmo.cs_cycles", 32'(n), 32'd1001);
    chk("notmo.done", 32'(bus.done), 32'd1);
    chk("notmo.err",  32'(bus.err), 32'd0);
    chk("notmo.rdat", bus.rdat, 32'h0BADF00D);
`endif
    bus.req = 2'b00;
    tick();

    // Randomized accesses against a transaction-level model
    do_reset();
    m_prio = 0;
    m_rdat = 32'd0;
    for (int it = 0; it < 150; it++) begin
      rq   = 2'($urandom_range(1, 3));
      wr   = 2'($urandom_range(0, 3));
      ra   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      dly  = $urandom_range(0, 3);
      rk   = $urandom_range(0, 3);      // 0,1 ack / 2 err / 3 ack+err
      ack  = (rk != 2);
      er   = (rk >= 2);
      crd  = $urandom;
      drop = ($urandom_range(0, 3) == 0);
      own  = (rq == 2'b11) ? m_prio : (rq[1] ? 1 : 0);
      eg   = (own == 1) ? 2'b10 : 2'b01;

      bus.req = rq; bus.write = wr; bus.addr = ra; bus.wdat = rd;
      wait_cs(8, w);
      chk("rnd.latency",   32'(w), 32'd1);
      chk("rnd.gnt",       32'(bus.gnt), 32'(eg));
      chk("rnd.cpu_write", 32'(bus.cpu_write), 32'(wr[own]));
      chk("rnd.cpu_addr",  bus.cpu_addr, ra[own*32 +: 32]);
      chk("rnd.cpu_wdat",  bus.cpu_wdat, rd[own*32 +: 32]);
      if (drop) bus.req = 2'b00;         // must not abort the access
      respond(dly, ack, er, crd, n);
      chk("rnd.cs_cycles", 32'(n), 32'(dly + 1));
      chk("rnd.done",      32'(bus.done), 32'(eg));
      chk("rnd.err",       32'(bus.err), er ? 32'(eg) : 32'd0);
      m_prio = 1 - own;
      if (ack && !er && !wr[own]) m_rdat = crd;
      chk("rnd.rdat", bus.rdat, m_rdat);
      bus.req = 2'b00;
      tick();
      chk("rnd.idle_gnt", 32'(bus.gnt), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
